// File: rtl/inst_streamer.sv
// inst_streamer: buffers a program of 32-bit instruction words and streams it
// into the CPU instruction port, followed by FLUSH all-zero words.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_wr_en, i_wr_data    append a word to the buffer (IDLE only)
//   i_clr                 empty the buffer and clear the overflow flag (IDLE only)
//   i_go                  stream the buffered program (IDLE only, count > 0)
//   o_start, o_inst       drive cpu.i_start / cpu.i_inst
//   o_busy                high while streaming or flushing
//   o_done                one-cycle pulse on return to IDLE
//   o_count, o_full       buffered word count, count == DEPTH
//   o_ovf                 sticky: a write was attempted while full
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | accept clear / go / write; outputs idle
// S_STREAM | o_inst presents buffered words, one per cycle
// S_FLUSH  | o_inst presents zero words, fcnt counts down to zero
module inst_streamer #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int FLUSH = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic        i_clr,
  input  logic        i_go,
  output logic        o_start,
  output logic [31:0] o_inst,
  output logic        o_busy,
  output logic        o_done,
  output logic [AW:0] o_count,
  output logic        o_full,
  output logic        o_ovf
);

  localparam int              FW       = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [FW-1:0]   FLUSH_LD = FW'(FLUSH - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW:0]   rd, rd_nxt, count_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          start_nxt, busy_nxt, done_nxt, ovf_nxt;
  logic [31:0]   inst_nxt;
  logic          wr_fire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Outputs are registered, so the go edge already loads mem[0] and the read
  // pointer moves to 1; STREAM then ends when rd catches up with the count.
  always_comb begin
    state_nxt = state;
    rd_nxt    = rd;
    fcnt_nxt  = fcnt;
    count_nxt = o_count;
    ovf_nxt   = o_ovf;
    start_nxt = o_start;
    busy_nxt  = o_busy;
    inst_nxt  = o_inst;
    done_nxt  = 1'b0;
    wr_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        start_nxt = 1'b0;
        busy_nxt  = 1'b0;
        inst_nxt  = '0;
        if (i_clr) begin
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end else if (i_go && (o_count != '0)) begin
          state_nxt = S_STREAM;
          start_nxt = 1'b1;
          busy_nxt  = 1'b1;
          inst_nxt  = mem[0];
          rd_nxt    = (AW+1)'(1);
        end else if (i_wr_en) begin
          if (o_count == FULL_CNT) begin
            ovf_nxt = 1'b1;
          end else begin
            wr_fire   = 1'b1;
            count_nxt = o_count + 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (rd == o_count) begin
          state_nxt = S_FLUSH;
          inst_nxt  = '0;
          fcnt_nxt  = FLUSH_LD;
        end else begin
          inst_nxt = mem[rd[AW-1:0]];
          rd_nxt   = rd + 1'b1;
        end
      end
      S_FLUSH: begin
        if (fcnt == '0) begin
          state_nxt = S_IDLE;
          start_nxt = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          rd_nxt    = '0;
        end else begin
          fcnt_nxt = fcnt - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd      <= '0;
      fcnt    <= '0;
      o_count <= '0;
      o_full  <= 1'b0;
      o_ovf   <= 1'b0;
      o_start <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_inst  <= '0;
    end else begin
      rd      <= rd_nxt;
      fcnt    <= fcnt_nxt;
      o_count <= count_nxt;
      o_full  <= (count_nxt == FULL_CNT);
      o_ovf   <= ovf_nxt;
      o_start <= start_nxt;
      o_busy  <= busy_nxt;
      o_done  <= done_nxt;
      o_inst  <= inst_nxt;
    end
  end

  // Program storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_fire) mem[o_count[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: tb/tb_inst_streamer.sv
module tb_inst_streamer;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;
  localparam int FLUSH   = 10;
  localparam int CAP_MAX = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        clr = 1'b0;
  logic        go = 1'b0;
  logic        o_start, o_busy, o_done, o_full, o_ovf;
  logic [31:0] o_inst;
  logic [AW:0] o_count;

  inst_streamer #(.DEPTH(DEPTH), .AW(AW), .FLUSH(FLUSH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_clr(clr), .i_go(go), .o_start(o_start), .o_inst(o_inst),
    .o_busy(o_busy), .o_done(o_done), .o_count(o_count), .o_full(o_full),
    .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: the program as a plain queue plus the sticky overflow.
  logic [31:0] model_prog[$];
  logic        model_ovf = 1'b0;

  logic        cap_start[CAP_MAX];
  logic        cap_busy[CAP_MAX];
  logic        cap_done[CAP_MAX];
  logic [31:0] cap_inst[CAP_MAX];
  int          cap_len = 0;

  function automatic logic [AW:0] model_cnt();
    return (AW+1)'(model_prog.size());
  endfunction

  // One IDLE-cycle operation, applied to both the DUT and the model.
  task automatic idle_cycle(input logic c, input logic g, input logic w, input logic [31:0] d);
    @(negedge clk);
    clr = c; go = g; wr_en = w; wr_data = d;
    @(posedge clk);
    #1;
    clr = 1'b0; go = 1'b0; wr_en = 1'b0;
    if (c) begin
      model_prog.delete();
      model_ovf = 1'b0;
    end else if (w) begin
      if (model_prog.size() < DEPTH) model_prog.push_back(d);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic kick_go();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  // Records outputs for a fixed number of cycles after the go edge; while
  // c < noise_until, random write/clear/go requests are thrown at the DUT.
  task automatic capture(input int cycles, input int noise_until);
    cap_len = cycles;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      cap_start[c] = o_start;
      cap_busy[c]  = o_busy;
      cap_done[c]  = o_done;
      cap_inst[c]  = o_inst;
      if (c < noise_until) begin
        wr_en   = 1'($urandom_range(0, 1));
        clr     = 1'($urandom_range(0, 1));
        go      = 1'($urandom_range(0, 1));
        wr_data = $urandom;
      end else begin
        wr_en = 1'b0; clr = 1'b0; go = 1'b0;
      end
    end
  endtask

  // Expected timeline after go: N program words, FLUSH zeros (start/busy high),
  // then a single done cycle with everything else low.
  function automatic int seq_errs();
    int n;
    int errs;
    logic es, ed;
    logic [31:0] ei;
    n = model_prog.size();
    errs = 0;
    for (int c = 0; c < cap_len; c++) begin
      es = (c < n + FLUSH);
      ed = (c == n + FLUSH);
      ei = (c < n) ? model_prog[c] : 32'h0;
      if (cap_start[c] !== es || cap_busy[c] !== es || cap_done[c] !== ed || cap_inst[c] !== ei)
        errs++;
    end
    return errs;
  endfunction

  function automatic int cap_sum_start();
    int s = 0;
    for (int c = 0; c < cap_len; c++) if (cap_start[c] === 1'b1) s++;
    return s;
  endfunction

  function automatic int cap_sum_done();
    int s = 0;
    for (int c = 0; c < cap_len; c++) if (cap_done[c] === 1'b1) s++;
    return s;
  endfunction

  task automatic test_reset();
    #12;
    total_cnt++; if (o_start !== 1'b0) $display("FAIL reset_start: got %b want 0", o_start); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else pass_cnt++;
    total_cnt++; if (o_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", o_inst); else pass_cnt++;
    total_cnt++; if (o_count !== '0) $display("FAIL reset_count: got %0d want 0", o_count); else pass_cnt++;
    total_cnt++; if ({o_full, o_ovf} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {o_full, o_ovf}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_prog.delete();
    model_ovf = 1'b0;
  endtask

  task automatic test_basic();
    int e;
    idle_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    idle_cycle(1'b0, 1'b0, 1'b1, 32'h00500093);
    idle_cycle(1'b0, 1'b0, 1'b1, 32'h00A00113);
    idle_cycle(1'b0, 1'b0, 1'b1, 32'h002081B3);
    @(negedge clk);
    total_cnt++; if (o_count !== 3'd3) $display("FAIL basic_count_loaded: got %0d want 3", o_count); else pass_cnt++;
    kick_go();
    capture(3 + FLUSH + 3, 0);
    e = seq_errs();
    total_cnt++; if (e !== 0) $display("FAIL basic_sequence: got %0d bad cycles want 0", e); else pass_cnt++;
    total_cnt++; if (cap_sum_start() !== 3 + FLUSH) $display("FAIL basic_start_len: got %0d want %0d", cap_sum_start(), 3 + FLUSH); else pass_cnt++;
    total_cnt++; if (cap_sum_done() !== 1) $display("FAIL basic_done_pulses: got %0d want 1", cap_sum_done()); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd3) $display("FAIL basic_count_after: got %0d want 3", o_count); else pass_cnt++;
  endtask

  task automatic test_fill_ovf();
    int e;
    idle_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 3; i++) idle_cycle(1'b0, 1'b0, 1'b1, 32'(i));
    @(negedge clk);
    total_cnt++; if (o_full !== 1'b0) $display("FAIL fill_full_at3: got %b want 0", o_full); else pass_cnt++;
    idle_cycle(1'b0, 1'b0, 1'b1, 32'h4);
    @(negedge clk);
    total_cnt++; if ({o_full, o_ovf} !== 2'b10) $display("FAIL fill_flags_at4: got %b want 10", {o_full, o_ovf}); else pass_cnt++;
    idle_cycle(1'b0, 1'b0, 1'b1, 32'h5);
    @(negedge clk);
    total_cnt++; if (o_ovf !== 1'b1) $display("FAIL fill_ovf_at5: got %b want 1", o_ovf); else pass_cnt++;
    total_cnt++; if (o_count !== model_cnt()) $display("FAIL fill_count: got %0d want %0d", o_count, model_cnt()); else pass_cnt++;
    kick_go();
    capture(DEPTH + FLUSH + 3, 0);
    e = seq_errs();
    total_cnt++; if (e !== 0) $display("FAIL fill_sequence: got %0d bad cycles want 0", e); else pass_cnt++;
    total_cnt++; if (cap_inst[DEPTH - 1] !== 32'h4 || cap_inst[DEPTH] !== 32'h0)
      $display("FAIL fill_last_word: got %h,%h want 4,0", cap_inst[DEPTH - 1], cap_inst[DEPTH]); else pass_cnt++;
  endtask

  task automatic test_empty_go_clear();
    idle_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    idle_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    capture(FLUSH + 5, 0);
    total_cnt++; if (cap_sum_start() + cap_sum_done() !== 0)
      $display("FAIL empty_go_run: got %0d start/done cycles want 0", cap_sum_start() + cap_sum_done()); else pass_cnt++;
    for (int i = 0; i < DEPTH + 1; i++) idle_cycle(1'b0, 1'b0, 1'b1, $urandom);
    idle_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    total_cnt++; if ({o_count, o_ovf, o_full} !== '0) $display("FAIL clear_after_ovf: got count %0d ovf %b full %b want 0", o_count, o_ovf, o_full); else pass_cnt++;
    idle_cycle(1'b0, 1'b0, 1'b1, $urandom);
    idle_cycle(1'b0, 1'b0, 1'b1, $urandom);
    idle_cycle(1'b1, 1'b1, 1'b1, $urandom);
    @(negedge clk);
    total_cnt++; if (o_count !== model_cnt() || o_ovf !== 1'b0) $display("FAIL clear_priority: got count %0d ovf %b want 0 0", o_count, o_ovf); else pass_cnt++;
    capture(FLUSH + 5, 0);
    total_cnt++; if (cap_sum_start() + cap_sum_done() !== 0)
      $display("FAIL clear_no_run: got %0d start/done cycles want 0", cap_sum_start() + cap_sum_done()); else pass_cnt++;
  endtask

  task automatic test_ignored();
    int e;
    idle_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) idle_cycle(1'b0, 1'b0, 1'b1, $urandom);
    kick_go();
    capture(DEPTH + FLUSH + 3, DEPTH + FLUSH);
    e = seq_errs();
    total_cnt++; if (e !== 0) $display("FAIL ignored_sequence: got %0d bad cycles want 0", e); else pass_cnt++;
    total_cnt++; if (o_count !== model_cnt()) $display("FAIL ignored_count: got %0d want %0d", o_count, model_cnt()); else pass_cnt++;
    total_cnt++; if (o_ovf !== model_ovf) $display("FAIL ignored_ovf: got %b want %b", o_ovf, model_ovf); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int e;
    int n;
    idle_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n = $urandom_range(1, DEPTH);
    for (int i = 0; i < n; i++) idle_cycle(1'b0, 1'b0, 1'b1, $urandom);
    kick_go();
    capture(n + FLUSH + 1, 0);
    e = seq_errs();
    total_cnt++; if (e !== 0) $display("FAIL b2b_first: got %0d bad cycles want 0", e); else pass_cnt++;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    capture(n + FLUSH + 3, 0);
    e = seq_errs();
    total_cnt++; if (e !== 0) $display("FAIL b2b_replay: got %0d bad cycles want 0", e); else pass_cnt++;
  endtask

  task automatic test_random();
    int e;
    int ops;
    for (int it = 0; it < 6; it++) begin
      ops = $urandom_range(1, 7);
      for (int j = 0; j < ops; j++) begin
        if ($urandom_range(0, 7) == 0) idle_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        else idle_cycle(1'b0, 1'b0, 1'b1, $urandom);
      end
      if (model_prog.size() == 0) idle_cycle(1'b0, 1'b0, 1'b1, $urandom);
      @(negedge clk);
      total_cnt++; if (o_count !== model_cnt() || o_ovf !== model_ovf || o_full !== (model_prog.size() == DEPTH))
        $display("FAIL rand_load_%0d: got count %0d ovf %b full %b want %0d %b", it, o_count, o_ovf, o_full, model_cnt(), model_ovf); else pass_cnt++;
      kick_go();
      capture(model_prog.size() + FLUSH + 3, 0);
      e = seq_errs();
      total_cnt++; if (e !== 0) $display("FAIL rand_run_%0d: got %0d bad cycles want 0", it, e); else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    idle_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) idle_cycle(1'b0, 1'b0, 1'b1, $urandom);
    kick_go();
    @(posedge clk);
    #1;
    total_cnt++; if (o_start !== 1'b1 || o_inst !== model_prog[1])
      $display("FAIL midrst_second_word: got %b %h want 1 %h", o_start, o_inst, model_prog[1]); else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({o_start, o_busy, o_done, o_full, o_ovf, o_inst, o_count} !== '0)
      $display("FAIL midrst_async: got start %b busy %b inst %h count %0d want all 0", o_start, o_busy, o_inst, o_count); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_prog.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    total_cnt++; if (o_count !== '0) $display("FAIL midrst_count: got %0d want 0", o_count); else pass_cnt++;
    kick_go();
    capture(FLUSH + 5, 0);
    total_cnt++; if (cap_sum_start() + cap_sum_done() !== 0)
      $display("FAIL midrst_go_ignored: got %0d start/done cycles want 0", cap_sum_start() + cap_sum_done()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_ovf();
    test_empty_go_clear();
    test_ignored();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
